// File: rtl/recon_order_sequencer.sv
// Order sequencer for the reconstruction datapath: flushes, warms up
// and qualifies the output whenever the difference order changes.
module recon_order_sequencer #(
   parameter int FIRST_TWO_DELAY = 16,
   parameter int STAGE_DELAY     = 44,
   parameter int TAIL_DELAY      = 3,
   parameter int FLUSH_CYCLES    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_en,
   input  logic       run,
   input  logic [1:0] n_req,
   input  logic       n_req_valid,
   output logic       n_req_ready,
   output logic [1:0] n_active,
   output logic       pipe_flush,
   output logic       start,
   output logic       out_valid,
   output logic [1:0] state,
   output logic [7:0] relock_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLUSH  = 2'd1,
      S_WARMUP = 2'd2,
      S_RUN    = 2'd3
   } state_t;

   localparam int LAT_1   = FIRST_TWO_DELAY + STAGE_DELAY * 1 + TAIL_DELAY;
   localparam int LAT_2   = FIRST_TWO_DELAY + STAGE_DELAY * 2 + TAIL_DELAY;
   localparam int LAT_3   = FIRST_TWO_DELAY + STAGE_DELAY * 3 + TAIL_DELAY;
   localparam int FCW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCW-1:0] FC_LAST = FCW'(FLUSH_CYCLES - 1);

   // The deepest order must still fit the 8-bit latency counter.
   if (LAT_3 > 255) begin : g_lat_check
      $error("warm-up latency exceeds 8-bit counter");
   end

   state_t         state_q, state_d;
   logic [1:0]     n_active_q, n_active_d;
   logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
   logic [7:0]     lat_q, lat_d;
   logic [7:0]     relock_q, relock_d;
   logic           pipe_flush_q, pipe_flush_d;
   logic           start_q, start_d;
   logic           accept;
   logic [1:0]     n_store;
   logic           n_change;
   logic [7:0]     lat_load;

   assign n_req_ready  = (state_q != S_FLUSH);
   assign accept       = n_req_valid & n_req_ready;
   assign n_store      = (n_req == 2'd0) ? 2'd1 : n_req;
   assign n_change     = accept & (n_store != n_active_q);
   assign n_active     = n_active_q;
   assign pipe_flush   = pipe_flush_q;
   assign start        = start_q;
   assign out_valid    = (state_q == S_RUN) & clk_en;
   assign state        = state_q;
   assign relock_count = relock_q;

   // Warm-up latency for the order that the datapath is about to run.
   always_comb begin
      unique case (n_active_q)
         2'd2:    lat_load = 8'(LAT_2);
         2'd3:    lat_load = 8'(LAT_3);
         default: lat_load = 8'(LAT_1);
      endcase
   end

   // Next-state, order register, counters and registered outputs.
   always_comb begin
      state_d     = state_q;
      n_active_d  = n_active_q;
      flush_cnt_d = '0;
      lat_d       = lat_q;
      relock_d    = relock_q;
      if (accept) begin
         n_active_d = n_store;
      end
      unique case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (!run) begin
               state_d = S_IDLE;
            end else if (flush_cnt_q == FC_LAST) begin
               state_d = S_WARMUP;
               lat_d   = lat_load;
            end else begin
               flush_cnt_d = flush_cnt_q + FCW'(1);
            end
         end
         S_WARMUP: begin
            if (!run) begin
               state_d = S_IDLE;
            end else if (n_change) begin
               state_d = S_FLUSH;
            end else if (clk_en) begin
               if (lat_q <= 8'd1) begin
                  state_d = S_RUN;
                  lat_d   = 8'd0;
               end else begin
                  lat_d = lat_q - 8'd1;
               end
            end
         end
         S_RUN: begin
            if (!run) begin
               state_d = S_IDLE;
            end else if (n_change) begin
               state_d = S_FLUSH;
            end
         end
      endcase
      if (state_d == S_FLUSH && state_q != S_FLUSH && relock_q != 8'hFF) begin
         relock_d = relock_q + 8'd1;
      end
      pipe_flush_d = (state_d == S_FLUSH);
      start_d      = (state_d == S_WARMUP) || (state_d == S_RUN);
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         n_active_q   <= 2'd1;
         flush_cnt_q  <= '0;
         lat_q        <= 8'd0;
         relock_q     <= 8'd0;
         pipe_flush_q <= 1'b0;
         start_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_active_q   <= n_active_d;
         flush_cnt_q  <= flush_cnt_d;
         lat_q        <= lat_d;
         relock_q     <= relock_d;
         pipe_flush_q <= pipe_flush_d;
         start_q      <= start_d;
      end
   end

endmodule

// File: doc/recon_order_sequencer.md
RECON_ORDER_SEQUENCER -- requirements
Module: recon_order_sequencer

Interface
REQ-001 Parameter FIRST_TWO_DELAY, default 16: front-end (difference + modulo residual) latency in clk_en samples.
REQ-002 Parameter STAGE_DELAY, default 44: latency of one anti-difference stage in clk_en samples.
REQ-003 Parameter TAIL_DELAY, default 3: sum/scale/DAC conversion latency in clk_en samples.
REQ-004 Parameter FLUSH_CYCLES, default 4: pipe_flush pulse length in clk cycles.
REQ-005 clk  input  1  single clock; all registers update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 clk_en  input  1  sample strobe shared with the reconstruction datapath.
REQ-008 run  input  1  operator enable; 0 forces IDLE.
REQ-009 n_req  input  2  requested difference order.
REQ-010 n_req_valid  input  1  order request valid.
REQ-011 n_req_ready  output  1  order request may be accepted this cycle.
REQ-012 n_active  output  2  order driven to the datapath n input, range 1..3.
REQ-013 pipe_flush  output  1  synchronous clear to the datapath.
REQ-014 start  output  1  datapath start/acquire enable.
REQ-015 out_valid  output  1  datapath dac_out is trustworthy this sample.
REQ-016 state  output  2  IDLE=0, FLUSH=1, WARMUP=2, RUN=3.
REQ-017 relock_count  output  8  saturating count of FLUSH entries.

Function
REQ-018 Handshake: request accepted when n_req_valid and n_req_ready are both 1 on a rising edge; n_req_ready = 1 in IDLE, WARMUP and RUN, 0 in FLUSH.
REQ-019 Accepted n_req=0 is stored as 1; values 1..3 are stored unchanged; n_active updates the cycle after acceptance.
REQ-020 IDLE: pipe_flush=0, start=0, out_valid=0; run=1 -> FLUSH next cycle.
REQ-021 FLUSH: pipe_flush=1 for exactly FLUSH_CYCLES clk cycles, counted regardless of clk_en; then -> WARMUP.
REQ-022 On each FLUSH entry, relock_count increments; it holds at 255.
REQ-023 WARMUP: start=1; the latency counter loads L = FIRST_TWO_DELAY + STAGE_DELAY*n_active + TAIL_DELAY on entry (defaults: n=1 ->63, n=2 ->107, n=3 ->151).
REQ-024 WARMUP counter: decrements only on clk_en cycles; the cycle the counter reaches 0 with clk_en -> RUN next cycle.
REQ-025 RUN: start=1, out_valid = clk_en (combinational qualifier of the registered RUN state).
REQ-026 Request accepted in RUN or WARMUP with stored value different from n_active: update n_active, -> FLUSH next cycle.
REQ-027 Request accepted in RUN or WARMUP with stored value equal to n_active: no state change, no flush.
REQ-028 Request accepted in IDLE: update n_active only; state stays IDLE.
REQ-029 run=0 in any non-IDLE state: -> IDLE next cycle; this has priority over a request-driven FLUSH.
REQ-030 run=0 with a simultaneous accepted request: n_active still updates.
REQ-031 run=0 during FLUSH: pipe_flush drops the next cycle; the flush counter clears.
REQ-032 Latency counter: 8 bits wide, unsigned; the parameter sum is computed at elaboration and must be at most 255.

Reset
REQ-033 While reset=1, on a rising edge: state=IDLE, n_active=1, pipe_flush=0, start=0, out_valid=0, relock_count=0, counters=0.
REQ-034 Reset asserted mid-FLUSH/WARMUP/RUN takes effect at the next edge and overrides all other inputs, including a same-cycle request.
REQ-035 Reset does not wait for clk_en.

Verification
REQ-036 Reset, then run=1, clk_en every cycle, n_active=1 -> pipe_flush high 4 cycles; start rises with WARMUP; out_valid first high 63 clk_en samples later; relock_count=1.
REQ-037 In RUN, request n_req=3 -> accepted the same cycle; n_active=3 next cycle; FLUSH 4 cycles; out_valid returns after 151 clk_en samples; relock_count=2.
REQ-038 In RUN, request equal to n_active (2) -> no flush, out_valid uninterrupted; n_req=0 while n_active=1 -> no flush.
REQ-039 clk_en every 4th cycle, n=2 -> flush still 4 clk cycles; WARMUP spans 107 clk_en pulses (~428 clk); out_valid is high only on clk_en cycles.
REQ-040 run=0 in the same cycle as an accepted n_req=2 during RUN -> IDLE next cycle, n_active=2, no FLUSH, relock_count unchanged.
REQ-041 reset asserted in WARMUP with a simultaneous valid request -> all outputs at reset values and n_active=1 next cycle; 300 forced flush entries -> relock_count saturates at 255.
